// File: rtl/message_slicer_fifo.sv
// Wide-word FIFO for the message slicer: power-of-two depth, wrapping
// pointers, and an occupancy count one bit wider than the pointers so that
// full and empty can be told apart.
module message_slicer_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 16,
    parameter int LOG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [LOG_DEPTH:0]    count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [LOG_DEPTH:0] COUNT_FULL = (LOG_DEPTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LOG_DEPTH-1:0]  wr_ptr;
    logic [LOG_DEPTH-1:0]  rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (count == COUNT_FULL);
    assign empty   = (count == '0);
    assign do_wr   = wr && !full;
    assign do_rd   = rd && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since only occupied entries are read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (LOG_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/message_slicer.sv
// Serialiser: buffers wide words and emits them one WIDTH-bit slice per clock,
// most-significant slice first. Words arriving while the buffer is full are
// dropped and latch a sticky error flag.
module message_slicer #(
    parameter int N_SLICES          = 4,
    parameter int LOG_N_SLICES      = 2,
    parameter int WIDTH             = 32,
    parameter int BUFFER_LENGTH     = 16,
    parameter int LOG_BUFFER_LENGTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH*N_SLICES-1:0] in_data,
    input  logic                      in_nd,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_nd,
    output logic                      error
);

    localparam int                         DATA_WIDTH = WIDTH * N_SLICES;
    localparam logic [LOG_N_SLICES-1:0]    LAST_SLICE = LOG_N_SLICES'(N_SLICES - 1);
    localparam logic [LOG_BUFFER_LENGTH:0] COUNT_FULL = (LOG_BUFFER_LENGTH+1)'(BUFFER_LENGTH);

    logic [DATA_WIDTH-1:0]        head;
    logic [LOG_BUFFER_LENGTH:0]   count;
    logic                         full;
    logic                         empty;
    logic                         push;
    logic                         pop;
    logic [LOG_N_SLICES-1:0]      slice_cnt;
    logic [WIDTH-1:0]             slices [N_SLICES];

    // Occupancy is judged on the registered count, before any same-edge pop.
    assign push = in_nd && (count < COUNT_FULL);
    assign pop  = !empty && (slice_cnt == LAST_SLICE);

    // Slice 0 is the most-significant WIDTH bits of the head word.
    for (genvar k = 0; k < N_SLICES; k++) begin : g_slice
        assign slices[k] = head[WIDTH*(N_SLICES-k)-1 -: WIDTH];
    end

    message_slicer_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUFFER_LENGTH),
        .LOG_DEPTH  (LOG_BUFFER_LENGTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (push),
        .wr_data (in_data),
        .rd      (pop),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Slice sequencing and output register; out_data holds while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_cnt <= '0;
            out_data  <= '0;
            out_nd    <= 1'b0;
        end else if (!empty) begin
            out_data <= slices[slice_cnt];
            out_nd   <= 1'b1;
            if (slice_cnt == LAST_SLICE) begin
                slice_cnt <= '0;
            end else begin
                slice_cnt <= slice_cnt + LOG_N_SLICES'(1);
            end
        end else begin
            out_nd <= 1'b0;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else if (in_nd && full) begin
            error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_message_slicer.sv
// Bench for message_slicer (N_SLICES=4, WIDTH=8, depth 4). A byte-queue
// reference model tracks pending output bytes; the number of wide words still
// held is the pending byte count rounded up to whole words.
module tb_message_slicer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_nd = 1'b0;
    logic [7:0]  out_data;
    logic        out_nd;
    logic        error;

    int tests = 0;
    int fails = 0;

    logic [7:0] q [$];
    logic [7:0] exp_data = '0;
    logic       exp_nd = 1'b0;
    logic       exp_err = 1'b0;
    logic [7:0] ctr = 8'd1;

    message_slicer #(
        .N_SLICES          (4),
        .LOG_N_SLICES      (2),
        .WIDTH             (8),
        .BUFFER_LENGTH     (4),
        .LOG_BUFFER_LENGTH (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_nd    (in_nd),
        .out_data (out_data),
        .out_nd   (out_nd),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model of one rising edge: emit the oldest pending byte (decided on the
    // state before this edge), then accept the new word if fewer than 4 words
    // were held.
    task automatic model_edge(input logic nd, input logic [31:0] d);
        int words;
        words = (q.size() + 3) / 4;
        if (q.size() > 0) begin
            exp_nd   = 1'b1;
            exp_data = q.pop_front();
        end else begin
            exp_nd = 1'b0;
        end
        if (nd) begin
            if (words < 4) begin
                for (int k = 0; k < 4; k++) q.push_back(8'(d >> (24 - 8*k)));
            end else begin
                exp_err = 1'b1;
            end
        end
    endtask

    task automatic step(input logic nd, input logic [31:0] d);
        @(negedge clk);
        in_nd   = nd;
        in_data = d;
        @(posedge clk);
        model_edge(nd, d);
        #1;
        check("out_nd", 32'(out_nd), 32'(exp_nd));
        if (exp_nd) check("out_data", 32'(out_data), 32'(exp_data));
        check("error", 32'(error), 32'(exp_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom);
    endtask

    function automatic logic [31:0] next_word();
        logic [31:0] w;
        w = {ctr, ctr + 8'd1, ctr + 8'd2, ctr + 8'd3};
        ctr = ctr + 8'd4;
        return w;
    endfunction

    task automatic async_reset();
        @(negedge clk);
        in_nd = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_nd", 32'(out_nd), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        q.delete();
        exp_nd   = 1'b0;
        exp_data = '0;
        exp_err  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Power-on reset held for 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        check("por_out_nd", 32'(out_nd), 32'd0);
        check("por_out_data", 32'(out_data), 32'd0);
        check("por_error", 32'(error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("idle_out_data", 32'(out_data), 32'd0);

        // Single word, with explicit per-slice expectations.
        step(1'b1, 32'hA1B2C3D4);
        step(1'b0, '0); check("single_s0", 32'(out_data), 32'hA1);
        step(1'b0, '0); check("single_s1", 32'(out_data), 32'hB2);
        step(1'b0, '0); check("single_s2", 32'(out_data), 32'hC3);
        step(1'b0, '0); check("single_s3", 32'(out_data), 32'hD4);
        step(1'b0, '0); check("single_done_nd", 32'(out_nd), 32'd0);
        check("single_hold", 32'(out_data), 32'hD4);

        // Back-to-back words.
        step(1'b1, 32'h01020304);
        step(1'b1, 32'h05060708);
        idle(10);

        // Rate-matched stream: one word every 4 cycles.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, next_word());
            idle(3);
        end
        idle(6);
        check("rate_no_error", 32'(error), 32'd0);

        // Random-data stream at one word per 5 cycles: pointers wrap.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, $urandom);
            idle(4);
        end
        idle(6);

        // Random bursty traffic, still below the overflow threshold on average.
        for (int i = 0; i < 60; i++) step(($urandom_range(0, 5) == 0), $urandom);
        idle(20);
        check("bursty_error", 32'(error), 32'(exp_err));

        // Mid-stream asynchronous reset.
        step(1'b1, $urandom);
        step(1'b1, $urandom);
        idle(2);
        async_reset();
        idle(3);

        // Overflow: strobe every cycle for 8 words.
        for (int i = 0; i < 8; i++) step(1'b1, $urandom);
        check("ovf_flag", 32'(error), 32'd1);
        idle(40);
        check("ovf_sticky", 32'(error), 32'd1);
        check("ovf_drained", 32'(q.size()), 32'd0);

        // Random traffic including overflows.
        for (int i = 0; i < 80; i++) step(($urandom_range(0, 2) != 0), $urandom);
        idle(30);

        async_reset();
        idle(2);
        check("final_error", 32'(error), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog bounding the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
